wallace_mult_pipe: RTL

WALLACE_MULT_PIPE -- requirements
Module: wallace_mult_pipe

---
 rtl/wallace_mult_pipe.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/wallace_mult_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | wallace_mult_pipe: pipelined signed/unsigned multiplier, Baugh-Wooley rows |
// | reduced by a carry-save Wallace tree, final CPA in the last stage.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module wallace_mult_pipe #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;

  typedef logic [WIDTH-1:0][PW-1:0] rows_t;

  function automatic int rows_after(input int n);
    return 2 * (n / 3) + (n % 3);
  endfunction

  function automatic int num_layers();
    int n;
    int l;
    n = WIDTH;
    l = 0;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      if (n > 2) begin
        n = rows_after(n);
        l = l + 1;
      end
    end
    return l;
  endfunction

  localparam int LAYERS = num_layers();

  function automatic int rows_at(input int p);
    int n;
    n = WIDTH;
    for (int i = 0; i < 2 * WIDTH; i++) begin
      if (i < p) n = rows_after(n);
    end
    return n;
  endfunction

  // First layer index handled by stage s; the last stage only does the final add.
  function automatic int bound(input int s);
    if (STAGES == 1) return (s == 0) ? 0 : LAYERS;
    if (s >= STAGES - 1) return LAYERS;
    return (s * LAYERS) / (STAGES - 1);
  endfunction

  // One word-level 3:2 layer over the first n rows; leftover rows pass through.
  function automatic rows_t csa_layer(input rows_t r, input int n);
    rows_t o;
    int    k;
    o = '0;
    k = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if ((i % 3 == 0) && (i + 2 < n)) begin
        o[k]     = r[i] ^ r[i+1] ^ r[i+2];
        o[k+1]   = ((r[i] & r[i+1]) | (r[i] & r[i+2]) | (r[i+1] & r[i+2])) << 1;
        k = k + 2;
      end else if ((i >= n - (n % 3)) && (i < n)) begin
        o[k] = r[i];
        k = k + 1;
      end
    end
    return o;
  endfunction

  function automatic rows_t apply_layers(input rows_t r, input int n0, input int cnt);
    rows_t t;
    int    n;
    t = r;
    n = n0;
    for (int l = 0; l < 2 * WIDTH; l++) begin
      if (l < cnt) begin
        t = csa_layer(t, n);
        n = rows_after(n);
      end
    end
    return t;
  endfunction

  function automatic logic [PW-1:0] sum_rows(input rows_t r);
    logic [PW-1:0] s;
    s = '0;
    for (int i = 0; i < WIDTH; i++) s = s + r[i];
    return s;
  endfunction

  logic              adv;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] stage_in_v;
  logic [PW-1:0]     prod_q;
  rows_t             pp;

  assign adv       = ~valid_q[STAGES-1] | out_ready;
  assign in_ready  = adv;
  assign out_valid = valid_q[STAGES-1];
  assign busy      = |valid_q;
  assign prod      = prod_q;

  // Baugh-Wooley: invert the mixed sign terms, corrections folded into row 0.
  always_comb begin
    pp = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp[i][i+j] = (a[j] & b[i]) ^
                     (signed_mode & ((i == WIDTH - 1) != (j == WIDTH - 1)));
      end
    end
    if (signed_mode) begin
      pp[0][WIDTH] = 1'b1;
      pp[0][PW-1]  = 1'b1;
    end
  end

  always_comb begin
    valid_d = valid_q;
    if (adv) valid_d = stage_in_v;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    rows_t rows_in;
    rows_t rows_out;

    if (s == 0) begin : g_first
      assign rows_in       = pp;
      assign stage_in_v[s] = in_valid;
    end else begin : g_next
      assign rows_in       = g_stage[s-1].g_reg.rows_q;
      assign stage_in_v[s] = valid_q[s-1];
    end

    assign rows_out = apply_layers(rows_in, rows_at(bound(s)), bound(s + 1) - bound(s));

    if (s < STAGES - 1) begin : g_reg
      rows_t rows_q;
      always_ff @(posedge clk) begin
        if (adv && stage_in_v[s]) rows_q <= rows_out;
      end
    end else begin : g_out
      // Loads only on a valid entry so bubbles leave the last result in place.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    prod_q <= '0;
        else if (adv && stage_in_v[s]) prod_q <= sum_rows(rows_out);
      end
    end
  end

endmodule
`default_nettype wire
